// File: rtl/avl_mem_arbiter.sv
// rtl/avl_mem_arbiter.sv - two-master to one-slave Avalon-MM arbiter
// Round-robin grant with stall lock; read responses routed through an in-order id FIFO.
module avl_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [AW-1:0]   m0_address,
  input  logic [DW/8-1:0] m0_byteenable,
  input  logic [DW-1:0]   m0_writedata,
  output logic            m0_waitrequest,
  output logic            m0_readdatavalid,
  output logic [DW-1:0]   m0_readdata,
  output logic [1:0]      m0_response,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [AW-1:0]   m1_address,
  input  logic [DW/8-1:0] m1_byteenable,
  input  logic [DW-1:0]   m1_writedata,
  output logic            m1_waitrequest,
  output logic            m1_readdatavalid,
  output logic [DW-1:0]   m1_readdata,
  output logic [1:0]      m1_response,
  output logic            s_read,
  output logic            s_write,
  output logic [AW-1:0]   s_address,
  output logic [DW/8-1:0] s_byteenable,
  output logic [DW-1:0]   s_writedata,
  input  logic            s_waitrequest,
  input  logic            s_readdatavalid,
  input  logic [DW-1:0]   s_readdata,
  input  logic [1:0]      s_response,
  output logic            err_rsp
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);

  logic               lock_q, lock_d;
  logic               lock_id_q, lock_id_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic [MAX_OUT-1:0] fifo_q, fifo_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic full, m0_ok, m1_ok;
  logic gnt_vld, gnt;
  logic accept, push, pop, head;

  // A read is not eligible while the FIFO is full; writes always are.
  assign full  = (count_q == FULL_CNT);
  assign m0_ok = (m0_read | m0_write) & ~(m0_read & full);
  assign m1_ok = (m1_read | m1_write) & ~(m1_read & full);

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    if (lock_q) begin
      gnt     = lock_id_q;
      gnt_vld = lock_id_q ? m1_ok : m0_ok;
    end else if (m0_ok && m1_ok) begin
      gnt_vld = 1'b1;
      gnt     = ~last_q;
    end else if (m0_ok) begin
      gnt_vld = 1'b1;
      gnt     = 1'b0;
    end else if (m1_ok) begin
      gnt_vld = 1'b1;
      gnt     = 1'b1;
    end
  end

  // Read wins when a master raises both strobes.
  assign s_read       = gnt_vld & (gnt ? m1_read : m0_read);
  assign s_write      = gnt_vld & (gnt ? (m1_write & ~m1_read) : (m0_write & ~m0_read));
  assign s_address    = (gnt_vld & gnt) ? m1_address    : m0_address;
  assign s_byteenable = (gnt_vld & gnt) ? m1_byteenable : m0_byteenable;
  assign s_writedata  = (gnt_vld & gnt) ? m1_writedata  : m0_writedata;

  assign accept         = gnt_vld & ~s_waitrequest;
  assign m0_waitrequest = ~(accept & ~gnt);
  assign m1_waitrequest = ~(accept & gnt);

  assign push = accept & s_read;
  assign pop  = s_readdatavalid & (count_q != '0);
  assign head = fifo_q[rd_ptr_q];

  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_response      = s_response;
  assign m1_response      = s_response;
  assign err_rsp          = err_q;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    last_d    = last_q;
    err_d     = err_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    if (gnt_vld && s_waitrequest) begin
      lock_d    = 1'b1;
      lock_id_d = gnt;
    end
    if (accept) begin
      lock_d = 1'b0;
      last_d = gnt;
    end
    if (push) begin
      fifo_d[wr_ptr_q] = gnt;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (s_readdatavalid && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      fifo_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
      err_q     <= err_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule
